// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader
// ----------------------------------------------------------------------------
// Boot-time program loader that sits directly upstream of the CPU core.
// It takes a framed byte stream from a byte-wide serial receiver, writes the
// payload into instruction/data RAM starting at address 0, and holds the core
// in reset until a frame passes its checksum.
//
// Frame format: SYNC_BYTE, LEN, LEN data bytes, CSUM
//   LEN  : payload length; 0 encodes 2^ADDR_W bytes
//   CSUM : 8-bit modulo-256 sum of the data bytes
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   rx_valid     in   receiver byte available
//   rx_data      in   received byte
//   rx_ready     out  loader accepts byte (transfer on rx_valid && rx_ready)
//   ram_write_en out  single-cycle RAM write strobe per data byte
//   ram_addr     out  RAM write address (holds when not strobing)
//   ram_data     out  RAM write data (holds when not strobing)
//   cpu_rst      out  core reset, active-high, low only once the load passed
//   done         out  load succeeded, core running
//   error        out  last frame failed (bad checksum or inter-byte timeout)
// ============================================================================
module prog_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          TIMEOUT   = 50000,
    parameter int          TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    // Timeout fires on the edge where the counter would reach TIMEOUT.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [7:0]          sum_q, sum_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

    logic                ram_write_en_q, ram_write_en_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [7:0]          ram_data_q, ram_data_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                accept;
    logic                in_frame;
    logic [ADDR_W-1:0]   len_field;
    logic [ADDR_W:0]     cnt_inc;

    assign rx_ready  = (state_q != S_RUN);
    assign accept    = rx_valid && rx_ready;
    assign in_frame  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign len_field = ADDR_W'(rx_data);
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        len_d          = len_q;
        sum_d          = sum_q;
        tmo_d          = '0;
        ram_write_en_d = 1'b0;
        ram_addr_d     = ram_addr_q;
        ram_data_d     = ram_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                if (accept) begin
                    // Zero length field sets the extra MSB, i.e. 2^ADDR_W bytes.
                    len_d   = {(len_field == '0), len_field};
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (accept) begin
                    ram_write_en_d = 1'b1;
                    ram_addr_d     = cnt_q[ADDR_W-1:0];
                    ram_data_d     = rx_data;
                    sum_d          = sum_q + rx_data;
                    cnt_d          = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end

            S_CSUM: begin
                // sum_q already includes the last data byte, since that byte
                // was registered on an earlier edge than this one.
                if (accept) begin
                    state_d = (rx_data == sum_q) ? S_RUN : S_ERR;
                end
            end

            S_RUN: begin
                state_d = S_RUN;
            end

            S_ERR: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d = S_LEN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Inter-byte timeout inside a frame; an accepted byte always wins.
        if (in_frame && !accept) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_ERR;
                tmo_d   = '0;
            end else begin
                tmo_d   = tmo_q + 1'b1;
            end
        end

        // Status outputs are registered images of the next state.
        cpu_rst_d = (state_d != S_RUN);
        done_d    = (state_d == S_RUN);
        error_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            len_q          <= '0;
            sum_q          <= '0;
            tmo_q          <= '0;
            ram_write_en_q <= 1'b0;
            ram_addr_q     <= '0;
            ram_data_q     <= '0;
            cpu_rst_q      <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            sum_q          <= sum_d;
            tmo_q          <= tmo_d;
            ram_write_en_q <= ram_write_en_d;
            ram_addr_q     <= ram_addr_d;
            ram_data_q     <= ram_data_d;
            cpu_rst_q      <= cpu_rst_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign ram_write_en = ram_write_en_q;
    assign ram_addr     = ram_addr_q;
    assign ram_data     = ram_data_q;
    assign cpu_rst      = cpu_rst_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader directly upstream of the CPU core.
- Receives a framed byte stream from a byte-wide serial receiver and writes it into instruction/data RAM from address 0.
- Holds the core in reset until a frame passes its checksum, then releases it.
- While cpu_rst is high, the top level routes RAM write port 1 (address, data, write enable) to this block.

Parameters:
- ADDR_W, 8: RAM address width. Also the length-field width; length 0 means 2^ADDR_W bytes.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT, 50000: idle cycles allowed between bytes inside a frame before abort.
- TIMEOUT_W, 16: width of the timeout counter. Must satisfy TIMEOUT < 2^TIMEOUT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  receiver byte available.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader accepts byte; transfer occurs on an edge where rx_valid && rx_ready.
- ram_write_en  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM write address.
- ram_data  out  8  RAM write data.
- cpu_rst  out  1  core reset, active-high.
- done  out  1  load succeeded; core running.
- error  out  1  last frame failed (bad checksum or timeout).

Behaviour:
Reset (async, immediate):
- state=IDLE; ram_write_en=0, ram_addr=0, ram_data=0, cpu_rst=1, done=0, error=0.
- Byte counter, checksum accumulator and timeout counter cleared.

rx_ready:
- Combinational from state: 1 in IDLE, LEN, DATA, CSUM, ERR; 0 in RUN.

States:
- IDLE: accepted byte == SYNC_BYTE -> LEN; any other byte is discarded, state unchanged.
- LEN: accepted byte latched as N (0 -> 2^ADDR_W); count=0, sum=0 -> DATA.
- DATA: each accepted byte b:
  - Next cycle: ram_write_en=1, ram_addr=count, ram_data=b.
  - sum=sum+b mod 256; count+1.
  - After the Nth byte -> CSUM. Counter is ADDR_W+1 bits; addresses never exceed N-1.
- CSUM: accepted byte compared to sum.
  - Equal -> RUN.
  - Not equal -> ERR.
  - The comparison uses the sum including the final data byte, even when that byte arrives on the immediately preceding cycle.
- RUN: cpu_rst=0 and done=1 from the cycle after the checksum byte is accepted. No further input accepted. Exit only via rst.
- ERR: error=1, cpu_rst=1, done=0.
  - Accepted SYNC_BYTE -> LEN and clears error on that edge.
  - Other bytes are discarded.

Write strobe:
- ram_write_en is a single-cycle pulse per data byte.
- Back-to-back bytes produce back-to-back pulses.
- ram_addr and ram_data hold their last values when not strobing.

Timeout:
- Counter clears on every accepted byte and on entry to LEN.
- Counter increments each cycle in LEN, DATA and CSUM when no byte is accepted.
- On reaching TIMEOUT -> ERR.
- Writes already issued are not undone.
- No timeout in IDLE, ERR or RUN.

Simultaneous events:
- rst dominates everything.
- A byte accepted on the same cycle the timeout would fire is accepted; the timeout does not fire.

cpu_rst:
- High in every state except RUN.
- Deasserts glitch-free from a register.

Test Plan:
1. A5,03,10,20,30,60 → writes (0,10),(1,20),(2,30), one cycle after each data byte. Cycle after 60 accepted: done=1, cpu_rst=0, rx_ready=0.
2. A5,02,11,22, checksum 34 (expected 33) → error=1, cpu_rst=1, done=0. Then A5,01,7F,7F → error clears on A5; done=1 after 7F checksum.
3. 00,FF,5A before A5,01,42,42 → no write strobes before the A5 frame; one write (0,42); done=1.
4. A5,00, bytes 00..FF back-to-back, checksum 80 → 256 consecutive strobes, addr 0..255, data=addr; done=1. Repeat with checksum 81 → error=1.
5. TIMEOUT=16: A5,02,11 then idle 16 cycles → error=1 exactly on the 16th idle cycle; write (0,11) occurred. Variant: second byte arrives on idle cycle 16 → accepted, no error.
6. Assert rst asynchronously mid-DATA, mid ram_write_en pulse → outputs drop to reset values before the next clock edge; state IDLE; a subsequent full frame loads correctly.
